// File: rtl/multi_one_shot_if.sv
// Control/trigger bundle for multi_one_shot.
//   enable   : per-channel enable (low forces the channel idle)
//   edge_sel : trigger edge select (00 rise, 01 fall, 10 both, 11 rise)
//   Start    : per-channel trigger inputs (may be asynchronous)
//   Shot     : per-channel registered output pulses
//   busy     : per-channel pulse-or-lockout indication
//   missed   : per-channel one-cycle dropped-edge flag
interface multi_one_shot_if #(
   parameter int unsigned CHANNELS = 4
);
   logic [CHANNELS-1:0] enable;
   logic [1:0]          edge_sel;
   logic [CHANNELS-1:0] Start;
   logic [CHANNELS-1:0] Shot;
   logic [CHANNELS-1:0] busy;
   logic [CHANNELS-1:0] missed;

   modport master (
      output enable, edge_sel, Start,
      input  Shot, busy, missed
   );

   modport slave (
      input  enable, edge_sel, Start,
      output Shot, busy, missed
   );
endinterface

// File: rtl/multi_one_shot.sv
// Per-channel edge-to-pulse generator with optional synchroniser, selectable
// trigger edge, PULSE_LEN-cycle output pulse and HOLDOFF-cycle lockout.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : multi_one_shot_if slave (enable, edge_sel, Start in; Shot, busy, missed out)
module multi_one_shot #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned PULSE_LEN   = 1,
   parameter int unsigned HOLDOFF     = 0,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned RETRIGGER   = 0
) (
   input  logic             clk,
   input  logic             reset,
   multi_one_shot_if.slave  bus
);

   localparam int unsigned MAX_CNT = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
   localparam int unsigned CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] PL_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] p;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] qual_c;
   logic [CHANNELS-1:0] qual_q;
   logic [CHANNELS-1:0] shot_q;
   logic [CHANNELS-1:0] busy_q;
   logic [CHANNELS-1:0] missed_q;
   state_t              state [CHANNELS];
   logic [CNT_W-1:0]    cnt   [CHANNELS];

   // Start synchroniser (bypassed when SYNC_STAGES is 0); runs regardless of enable
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = bus.Start;
      end else begin : g_sync
         logic [CHANNELS-1:0] chain [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                  chain[i] <= '0;
               end
            end else begin
               chain[0] <= bus.Start;
               for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                  chain[i] <= chain[i-1];
               end
            end
         end
         assign s = chain[SYNC_STAGES-1];
      end
   endgenerate

   // Edge detect against the previous sample
   assign rise = s & ~p;
   assign fall = ~s & p;

   always_comb begin
      qual_c = rise;
      case (bus.edge_sel)
         2'b01:   qual_c = fall;
         2'b10:   qual_c = rise | fall;
         default: qual_c = rise;
      endcase
   end

   // Previous-sample and qualified-edge registers (the latter adds the post-p stage)
   always_ff @(posedge clk) begin
      if (reset) begin
         p      <= '0;
         qual_q <= '0;
      end else begin
         p      <= s;
         qual_q <= qual_c;
      end
   end

   // Per-channel IDLE -> PULSE -> HOLD state machines with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
         end
         shot_q   <= '0;
         busy_q   <= '0;
         missed_q <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            shot_q[i]   <= 1'b0;
            busy_q[i]   <= 1'b0;
            missed_q[i] <= 1'b0;
            if (!bus.enable[i]) begin
               state[i] <= ST_IDLE;
               cnt[i]   <= '0;
            end else begin
               case (state[i])
                  ST_IDLE: begin
                     if (qual_q[i]) begin
                        state[i]  <= ST_PULSE;
                        cnt[i]    <= PL_LOAD;
                        shot_q[i] <= 1'b1;
                        busy_q[i] <= 1'b1;
                     end
                  end
                  ST_PULSE: begin
                     if (qual_q[i] && (RETRIGGER != 0)) begin
                        // Retrigger stretches the pulse from this edge
                        cnt[i]    <= PL_LOAD;
                        shot_q[i] <= 1'b1;
                        busy_q[i] <= 1'b1;
                     end else begin
                        missed_q[i] <= qual_q[i];
                        if (cnt[i] == '0) begin
                           if (HOLDOFF == 0) begin
                              state[i] <= ST_IDLE;
                           end else begin
                              state[i]  <= ST_HOLD;
                              cnt[i]    <= HO_LOAD;
                              busy_q[i] <= 1'b1;
                           end
                        end else begin
                           cnt[i]    <= cnt[i] - CNT_W'(1);
                           shot_q[i] <= 1'b1;
                           busy_q[i] <= 1'b1;
                        end
                     end
                  end
                  ST_HOLD: begin
                     missed_q[i] <= qual_q[i];
                     if (cnt[i] == '0) begin
                        state[i] <= ST_IDLE;
                     end else begin
                        cnt[i]    <= cnt[i] - CNT_W'(1);
                        busy_q[i] <= 1'b1;
                     end
                  end
                  default: begin
                     state[i] <= ST_IDLE;
                     cnt[i]   <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.Shot   = shot_q;
   assign bus.busy   = busy_q;
   assign bus.missed = missed_q;

endmodule

// File: tb/tb_multi_one_shot.sv
// Scoreboard bench for multi_one_shot: six instances with different parameter
// sets share one stimulus; each directed row pushes the expected outputs of the
// instance under test, and a negedge monitor pops and compares.
module tb_multi_one_shot;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] enable;
   logic [1:0] edge_sel;
   logic [3:0] start;
   logic [2:0] sel;
   int         row;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [2:0] sel;
      logic [3:0] shot;
      logic [3:0] busy;
      logic [3:0] missed;
      int         row;
   } exp_t;

   exp_t sb [$];
   exp_t e;

   logic [3:0] shot_v   [6];
   logic [3:0] busy_v   [6];
   logic [3:0] missed_v [6];

   always #5 clk = ~clk;

   multi_one_shot_if #(.CHANNELS(4)) bus [6] ();

   // 0: defaults, 1: PL3/HO2, 2: PL4, 3: PL4 retrigger, 4: PL1/HO3, 5: PL5
   for (genvar g = 0; g < 6; g++) begin : g_dut
      multi_one_shot #(
         .CHANNELS   (4),
         .PULSE_LEN  ((g == 1) ? 3 : ((g == 2) || (g == 3)) ? 4 : (g == 5) ? 5 : 1),
         .HOLDOFF    ((g == 1) ? 2 : (g == 4) ? 3 : 0),
         .SYNC_STAGES(2),
         .RETRIGGER  ((g == 3) ? 1 : 0)
      ) u_dut (
         .clk  (clk),
         .reset(reset),
         .bus  (bus[g])
      );
      assign bus[g].enable   = enable;
      assign bus[g].edge_sel = edge_sel;
      assign bus[g].Start    = start;
      assign shot_v[g]       = bus[g].Shot;
      assign busy_v[g]       = bus[g].busy;
      assign missed_v[g]     = bus[g].missed;
   end

   // One row: expectation for outputs after this edge, then inputs for the next edge
   task automatic step(input logic r, input logic [3:0] en, input logic [1:0] es,
                       input logic [3:0] st, input logic [3:0] x_shot,
                       input logic [3:0] x_busy, input logic [3:0] x_missed);
      exp_t t;
      @(posedge clk);
      #1;
      row++;
      t.sel    = sel;
      t.shot   = x_shot;
      t.busy   = x_busy;
      t.missed = x_missed;
      t.row    = row;
      sb.push_back(t);
      reset    = r;
      enable   = en;
      edge_sel = es;
      start    = st;
   endtask

   // Monitor: compare the selected instance whenever an expectation is pending
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (shot_v[e.sel] !== e.shot || busy_v[e.sel] !== e.busy ||
             missed_v[e.sel] !== e.missed) begin
            errors++;
            $display("FAIL row%0d dut%0d shot/busy/missed got %h/%h/%h expected %h/%h/%h",
                     e.row, e.sel, shot_v[e.sel], busy_v[e.sel], missed_v[e.sel],
                     e.shot, e.busy, e.missed);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      enable   = 4'hF;
      edge_sel = 2'b00;
      start    = 4'hF;
      sel      = 3'd0;
      row      = 0;

      // Reset held 4 edges with Start high, then all channels pulse on release
      repeat (3) step(1'b1, 4'hF, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0);
      step(1'b0, 4'hF, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0);
      repeat (3) step(1'b0, 4'hF, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0);
      step(1'b0, 4'hF, 2'd0, 4'hF, 4'hF, 4'hF, 4'h0);
      step(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
      repeat (8) step(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);

      // Both-edge mode: Start[1] high 4 cycles -> pulses 4 cycles apart
      for (int i = 0; i < 10; i++)
         step(1'b0, 4'hF, 2'd2, (i < 4) ? 4'h2 : 4'h0,
              ((i == 4) || (i == 8)) ? 4'h2 : 4'h0,
              ((i == 4) || (i == 8)) ? 4'h2 : 4'h0, 4'h0);
      repeat (8) step(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);

      // PULSE_LEN=3, HOLDOFF=2: held Start gives one 3-cycle Shot, 5-cycle busy
      sel = 3'd1;
      for (int i = 0; i < 19; i++)
         step(1'b0, 4'hF, 2'd0, (i < 10) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 6)) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 8)) ? 4'h1 : 4'h0, 4'h0);

      // PULSE_LEN=4, edges 2 cycles apart, no retrigger: 4 cycles + missed
      sel = 3'd2;
      for (int i = 0; i < 14; i++)
         step(1'b0, 4'hF, 2'd2, (i < 2) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 7)) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 7)) ? 4'h1 : 4'h0,
              (i == 6) ? 4'h1 : 4'h0);

      // Same stimulus with retrigger: 6-cycle Shot, no missed
      sel = 3'd3;
      for (int i = 0; i < 14; i++)
         step(1'b0, 4'hF, 2'd2, (i < 2) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 9)) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 9)) ? 4'h1 : 4'h0, 4'h0);

      // HOLDOFF=3: second rise inside lockout is dropped and flagged
      sel = 3'd4;
      for (int i = 0; i < 14; i++)
         step(1'b0, 4'hF, 2'd0, ((i == 0) || (i == 2)) ? 4'h1 : 4'h0,
              (i == 4) ? 4'h1 : 4'h0,
              ((i >= 4) && (i <= 7)) ? 4'h1 : 4'h0,
              (i == 6) ? 4'h1 : 4'h0);

      // PULSE_LEN=5: enable[2] dropped in pulse cycle 2, re-enabled with Start high
      sel = 3'd5;
      for (int i = 0; i < 16; i++)
         step(1'b0, ((i >= 5) && (i <= 7)) ? 4'hB : 4'hF, 2'd0, 4'h4,
              ((i == 4) || (i == 5)) ? 4'h4 : 4'h0,
              ((i == 4) || (i == 5)) ? 4'h4 : 4'h0, 4'h0);
      repeat (6) step(1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0);

      // Drain scoreboard
      repeat (3) @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
